sccb_slave: RTL and testbench
=============================

SCCB_SLAVE -- requirements
Module: sccb_slave

Interface
REQ-001 Parameter DEV_ID, default 7'h21, 7-bit SCCB device ID this target answers (write ID 0x42, read ID 0x43).
REQ-002 sccb_clk  input  1  system clock; at least 8x the sio_c frequency.
REQ-003 sccb_reset_n  input  1  reset; asynchronous, active-low; clock sccb_clk.
REQ-004 sio_c  input  1  SCCB clock from the master.
REQ-005 sio_d  inout  1  SCCB data; the target drives 0 or releases to z, never drives 1.
REQ-006 reg_addr  output  8  register pointer presented with reg_we and reg_re.
REQ-007 reg_wdata  output  8  write data, valid while reg_we is high.
REQ-008 reg_we  output  1  one-cycle write strobe.
REQ-009 reg_re  output  1  one-cycle read strobe.
REQ-010 reg_rdata  input  8  read data, valid the cycle after reg_re.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 debug_out  output  8  {sio_c_s, sio_d_s, sio_d_oe, busy, 1'b0, state[2:0]}.

Function
REQ-013 sio_c and sio_d SHALL each pass through a 2-flop synchronizer (reset value 1) plus one history flop; all decisions use the synchronized values sio_c_s and sio_d_s.
REQ-014 Start SHALL be detected when sio_d_s falls while sio_c_s is 1 in both the current and previous cycle.
REQ-015 Stop SHALL be detected when sio_d_s rises under the same sio_c_s condition.
REQ-016 Data bits SHALL be sampled on the rising edge of sio_c_s, MSB first.
REQ-017 A bit counter 0..8 SHALL track each byte; bit 8 is the ninth (don't-care/ACK) bit.
REQ-018 States SHALL be IDLE, ID, SUBADDR, WDATA, RDATA and IGNORE.
REQ-019 Start from any state SHALL go to ID and clear the bit counter; this also covers repeated start.
REQ-020 Stop from any state SHALL go to IDLE; any partial byte SHALL be discarded without a strobe.
REQ-021 ID handling after the 8th bit:
- byte[7:1] != DEV_ID -> IGNORE;
- match with byte[0]=0 -> SUBADDR;
- match with byte[0]=1 -> RDATA.
REQ-022 SUBADDR SHALL load the received byte into the pointer, then go to WDATA.
REQ-023 WDATA, after the 8th bit: reg_we high for exactly 1 cycle with reg_addr=pointer and reg_wdata=byte.
- The pointer then increments, wrapping 8'hFF -> 8'h00.
- Further bytes repeat the write.
REQ-024 On RDATA entry (falling sio_c_s that ends the ID ninth bit): reg_re pulses 1 cycle with reg_addr=pointer.
- reg_rdata is captured into the transmit shifter the next cycle.
REQ-025 In RDATA the target SHALL drive sio_d low for 0 bits and release it for 1 bits, changing the bit only on falling sio_c_s, and SHALL release sio_d for the ninth bit.
REQ-026 RDATA ninth bit from the master:
- sampled 1 (NA) -> IGNORE;
- sampled 0 -> pointer increments, reg_re pulses, and the next byte is sent.
REQ-027 sio_d output enable SHALL change only on falling sio_c_s, never while sio_c_s is high.
REQ-028 reg_we and reg_re SHALL never be high in the same cycle.
REQ-029 Edge-to-sample latency SHALL be 3 sccb_clk cycles; the transmit output change SHALL be 1 cycle after falling sio_c_s is detected.

Reset
REQ-030 Reset values: state IDLE, pointer 8'h00, reg_addr 8'h00, reg_wdata 8'h00, reg_we 0, reg_re 0, busy 0, sio_d released.
REQ-031 Reset mid-transfer SHALL abort immediately; no strobe SHALL be issued for the aborted byte.

Configuration
REQ-032 With macro SCCB_SLAVE_ACK_EN defined, the target SHALL drive sio_d low during the ninth bit after:
- a matching ID;
- a SUBADDR byte;
- each WDATA byte.
The drive is asserted on the falling sio_c_s after bit 7 and released on the next falling sio_c_s.
REQ-033 Without SCCB_SLAVE_ACK_EN, sio_d SHALL stay released during every ninth bit.

Structure
REQ-034 The shared package sccb_pkg SHALL hold the 3-bit state encodings and the ID read/write bit constants.
REQ-035 A sub-module sccb_sync (2-flop synchronizer plus rise/fall detect) SHALL be instantiated twice, once for sio_c and once for sio_d.

Verification
REQ-036 3-phase write: START, 0x42, 0x12, 0x80, STOP -> one reg_we pulse with addr 0x12, data 0x80; busy 0 after STOP.
REQ-037 Read: 0x42, 0x0A, STOP, then START, 0x43 with reg_rdata=0x76 and NA -> reg_re addr 0x0A; sio_d bits 0,1,1,1,0,1,1,0; then IGNORE and sio_d released.
REQ-038 ID mismatch: START, 0x60, 0x12, 0x80, STOP -> no strobes; sio_d never driven.
REQ-039 Repeated START after 4 WDATA bits, then 0x42, 0x05, 0x33 -> only one reg_we, addr 0x05, data 0x33.
REQ-040 sccb_reset_n low during an RDATA byte holding bit 0 -> sio_d released and busy 0 while reset is low.
REQ-041 Write 0x42, 0x12, 0x80 -> sio_d low on the ninth clock of all three bytes with SCCB_SLAVE_ACK_EN defined; z on all three without it.

Source files
------------

// File: rtl/sccb_slave_pkg.sv
// Shared SCCB target definitions: 3-bit FSM encodings and ID read/write bit values.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID      = 3'd1,
    ST_SUBADDR = 3'd2,
    ST_WDATA   = 3'd3,
    ST_RDATA   = 3'd4,
    ST_IGNORE  = 3'd5
  } state_t;

  localparam logic ID_WR_BIT = 1'b0;
  localparam logic ID_RD_BIT = 1'b1;

endpackage

// File: rtl/sccb_slave_if.sv
// Register-bus interface between the SCCB target and the register file it fronts.
interface sccb_slave_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport slave  (output reg_addr, reg_wdata, reg_we, reg_re, input  reg_rdata);
  modport master (input  reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/sccb_slave_sync.sv
// Two-flop synchronizer (idle-high reset) with a history flop for rise/fall detection.
module sccb_sync (
  input  logic sccb_clk,
  input  logic sccb_reset_n,
  input  logic i_in,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta, r_sync, r_hist;

  always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 1'b1;
    end else begin
      r_meta <= i_in;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_s    = r_sync;
  assign o_rise = r_sync & ~r_hist;
  assign o_fall = ~r_sync & r_hist;
endmodule

// File: rtl/sccb_slave.sv
// SCCB target: ID/sub-address/write/read FSM driving a one-cycle register strobe bus.
// Define SCCB_SLAVE_ACK_EN to pull sio_d low on the ninth bit of accepted bytes.
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ID = 7'h21
) (
  input  logic         sccb_clk,
  input  logic         sccb_reset_n,
  input  logic         sio_c,
  inout  wire          sio_d,
  sccb_slave_if.slave  reg_if,
  output logic         busy,
  output logic [7:0]   debug_out
);

`ifdef SCCB_SLAVE_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  logic w_c_s, w_c_rise, w_c_fall;
  logic w_d_s, w_d_rise, w_d_fall;

  sccb_sync u_sync_c (.sccb_clk(sccb_clk), .sccb_reset_n(sccb_reset_n), .i_in(sio_c),
                      .o_s(w_c_s), .o_rise(w_c_rise), .o_fall(w_c_fall));
  sccb_sync u_sync_d (.sccb_clk(sccb_clk), .sccb_reset_n(sccb_reset_n), .i_in(sio_d),
                      .o_s(w_d_s), .o_rise(w_d_rise), .o_fall(w_d_fall));

  state_t     r_state;
  logic [3:0] r_bitcnt;
  logic [7:0] r_shift, r_ptr, r_tx;
  logic       r_oe, r_ack, r_rd_req, r_rd_cap;

  // sio_c_s high now and in the previous cycle is equivalent to high without a rise.
  logic       w_start, w_stop;
  logic [7:0] w_byte;
  assign w_start = w_d_fall & w_c_s & ~w_c_rise;
  assign w_stop  = w_d_rise & w_c_s & ~w_c_rise;
  assign w_byte  = {r_shift[6:0], w_d_s};

  always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      r_state          <= ST_IDLE;
      r_bitcnt         <= 4'd0;
      r_shift          <= 8'h00;
      r_ptr            <= 8'h00;
      r_tx             <= 8'h00;
      r_oe             <= 1'b0;
      r_ack            <= 1'b0;
      r_rd_req         <= 1'b0;
      r_rd_cap         <= 1'b0;
      reg_if.reg_addr  <= 8'h00;
      reg_if.reg_wdata <= 8'h00;
      reg_if.reg_we    <= 1'b0;
      reg_if.reg_re    <= 1'b0;
    end else begin
      reg_if.reg_we <= 1'b0;
      reg_if.reg_re <= 1'b0;
      r_rd_cap      <= reg_if.reg_re;
      if (w_start || w_stop) begin
        r_state  <= w_start ? ST_ID : ST_IDLE;
        r_bitcnt <= 4'd0;
        r_ack    <= 1'b0;
        r_rd_req <= 1'b0;
        r_oe     <= 1'b0;
      end else if (w_c_rise && r_state != ST_IDLE && r_state != ST_IGNORE) begin
        if (r_bitcnt != 4'd8) begin
          r_shift  <= w_byte;
          r_bitcnt <= r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) begin
            case (r_state)
              ST_ID: begin
                if (w_byte[7:1] != DEV_ID) begin
                  r_state <= ST_IGNORE;
                  r_ack   <= 1'b0;
                end else begin
                  r_ack <= 1'b1;
                  if (w_byte[0] == ID_RD_BIT) r_rd_req <= 1'b1;
                  else                        r_state  <= ST_SUBADDR;
                end
              end
              ST_SUBADDR: begin
                r_ptr   <= w_byte;
                r_state <= ST_WDATA;
                r_ack   <= 1'b1;
              end
              ST_WDATA: begin
                reg_if.reg_we    <= 1'b1;
                reg_if.reg_addr  <= r_ptr;
                reg_if.reg_wdata <= w_byte;
                r_ptr            <= r_ptr + 8'd1;
                r_ack            <= 1'b1;
              end
              default: r_ack <= 1'b0;
            endcase
          end
        end else begin
          // Ninth bit: in RDATA it is the master's ACK (0) / NA (1).
          r_bitcnt <= 4'd0;
          if (r_state == ST_RDATA) begin
            if (w_d_s) begin
              r_state <= ST_IGNORE;
            end else begin
              r_ptr    <= r_ptr + 8'd1;
              r_rd_req <= 1'b1;
            end
          end
        end
      end else if (w_c_fall && r_state != ST_IDLE) begin
        if (r_rd_req && r_bitcnt == 4'd0) begin
          r_state         <= ST_RDATA;
          r_rd_req        <= 1'b0;
          reg_if.reg_re   <= 1'b1;
          reg_if.reg_addr <= r_ptr;
          r_oe            <= 1'b0;
        end else if (r_state == ST_RDATA) begin
          r_oe <= (r_bitcnt != 4'd0 && r_bitcnt != 4'd8) ? ~r_tx[3'(4'd7 - r_bitcnt)] : 1'b0;
        end else begin
          r_oe <= ACK_EN && r_state != ST_IGNORE && r_bitcnt == 4'd8 && r_ack;
        end
      end else if (r_rd_cap && r_state == ST_RDATA) begin
        // First bit of a read byte goes out as soon as the register data lands.
        r_tx <= reg_if.reg_rdata;
        r_oe <= ~reg_if.reg_rdata[7];
      end
    end
  end

  assign sio_d     = r_oe ? 1'b0 : 1'bz;
  assign busy      = (r_state != ST_IDLE);
  assign debug_out = {w_c_s, w_d_s, r_oe, busy, 1'b0, r_state};

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: bus-level SCCB master, strobe scoreboard, line-level checks.
module tb_sccb_slave;
  import sccb_pkg::*;

  localparam int Q = 4;
`ifdef SCCB_SLAVE_ACK_EN
  localparam logic [7:0] EXP_ACK = 8'd1;
`else
  localparam logic [7:0] EXP_ACK = 8'd0;
`endif

  logic       sccb_clk = 1'b0;
  logic       sccb_reset_n = 1'b0;
  logic       sio_c = 1'b1;
  logic       m_low = 1'b0;
  wire        sio_d;
  logic       busy;
  logic [7:0] dbg;

  assign sio_d = m_low ? 1'b0 : 1'bz;
  pullup (sio_d);

  sccb_slave_if rif();

  sccb_slave #(.DEV_ID(7'h21)) dut (
    .sccb_clk    (sccb_clk),
    .sccb_reset_n(sccb_reset_n),
    .sio_c       (sio_c),
    .sio_d       (sio_d),
    .reg_if      (rif.slave),
    .busy        (busy),
    .debug_out   (dbg)
  );

  always #5 sccb_clk = ~sccb_clk;

  function automatic logic [7:0] rd_model(input logic [7:0] a);
    return (a == 8'h0A) ? 8'h76 : (a ^ 8'hA5);
  endfunction

  always @(posedge sccb_clk) if (rif.reg_re) rif.reg_rdata <= rd_model(rif.reg_addr);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {logic rd; logic [7:0] addr; logic [7:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic mon_oe_en = 1'b1;
  logic prev_oe = 1'b0;
  int   oe_cycles = 0;

  // Scoreboard monitor: every strobe pops one expected entry.
  always @(negedge sccb_clk) begin
    if (rif.reg_we || rif.reg_re) begin
      if (rif.reg_we && rif.reg_re) chk("strobe_overlap", 8'd1, 8'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {6'd0, rif.reg_re, rif.reg_we}, 8'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", 8'(rif.reg_re), 8'(e.rd));
        chk("strobe_addr", rif.reg_addr, e.addr);
        if (!e.rd) chk("strobe_wdata", rif.reg_wdata, e.data);
      end
    end
    if (dbg[5]) oe_cycles++;
    if (mon_oe_en && dbg[5] != prev_oe) chk("oe_change_with_sioc_high", 8'(dbg[7]), 8'd0);
    prev_oe = dbg[5];
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sccb_clk);
  endtask

  task automatic bus_start;
    m_low = 1'b0; sio_c = 1'b1; cyc(Q);
    m_low = 1'b1; cyc(Q);
    sio_c = 1'b0; cyc(Q);
  endtask

  task automatic bus_stop;
    m_low = 1'b1; cyc(Q);
    sio_c = 1'b1; cyc(Q);
    m_low = 1'b0; cyc(Q);
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    m_low = ~b; cyc(Q);
    sio_c = 1'b1; cyc(Q);
    seen = sio_d; cyc(Q);
    sio_c = 1'b0; cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(v[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v);
    logic s;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      v = {v[6:0], s};
    end
    bus_bit(~mack, s);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic a;
    bus_start;
    send_byte(8'h42, a); chk("ptr_id_ack", 8'(a), EXP_ACK);
    send_byte(p, a);     chk("ptr_sub_ack", 8'(a), EXP_ACK);
    bus_stop;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a, s;
    logic [7:0] v;
    int         oe0;

    cyc(3);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_debug", dbg, 8'hC0);
    chk("rst_addr", rif.reg_addr, 8'h00);
    chk("rst_wdata", rif.reg_wdata, 8'h00);
    chk("rst_strobes", {6'd0, rif.reg_re, rif.reg_we}, 8'd0);
    sccb_reset_n = 1'b1;
    cyc(4);

    // 3-phase write
    sb.push_back('{rd: 1'b0, addr: 8'h12, data: 8'h80});
    bus_start;
    chk("busy_after_start", 8'(busy), 8'd1);
    send_byte(8'h42, a); chk("wr_id_ack", 8'(a), EXP_ACK);
    send_byte(8'h12, a); chk("wr_sub_ack", 8'(a), EXP_ACK);
    send_byte(8'h80, a); chk("wr_data_ack", 8'(a), EXP_ACK);
    bus_stop;
    cyc(4);
    chk("wr_busy_after_stop", 8'(busy), 8'd0);
    chk("wr_sb_empty", 8'(sb.size()), 8'd0);

    // Read with NA
    set_ptr(8'h0A);
    sb.push_back('{rd: 1'b1, addr: 8'h0A, data: 8'h00});
    bus_start;
    send_byte(8'h43, a); chk("rd_id_ack", 8'(a), EXP_ACK);
    recv_byte(1'b0, v);
    chk("rd_byte", v, 8'h76);
    cyc(2);
    chk("rd_ignore_state", 8'(dbg[2:0]), 8'(ST_IGNORE));
    chk("rd_released_oe", 8'(dbg[5]), 8'd0);
    chk("rd_released_line", 8'(sio_d), 8'd1);
    bus_stop;
    cyc(4);
    chk("rd_busy_after_stop", 8'(busy), 8'd0);
    chk("rd_sb_empty", 8'(sb.size()), 8'd0);

    // ID mismatch
    oe0 = oe_cycles;
    bus_start;
    send_byte(8'h60, a); chk("mm_id_ack", 8'(a), 8'd0);
    send_byte(8'h12, a); chk("mm_sub_ack", 8'(a), 8'd0);
    send_byte(8'h80, a); chk("mm_data_ack", 8'(a), 8'd0);
    bus_stop;
    cyc(4);
    chk("mm_never_driven", 8'(oe_cycles - oe0), 8'd0);
    chk("mm_busy", 8'(busy), 8'd0);

    // Repeated start after a partial data byte
    sb.push_back('{rd: 1'b0, addr: 8'h05, data: 8'h33});
    bus_start;
    send_byte(8'h42, a);
    send_byte(8'h12, a);
    bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b0, s);
    bus_start;
    send_byte(8'h42, a); chk("rs_id_ack", 8'(a), EXP_ACK);
    send_byte(8'h05, a);
    send_byte(8'h33, a); chk("rs_data_ack", 8'(a), EXP_ACK);
    bus_stop;
    cyc(4);
    chk("rs_sb_empty", 8'(sb.size()), 8'd0);

    // Pointer wraps FF -> 00 across a burst write
    sb.push_back('{rd: 1'b0, addr: 8'hFF, data: 8'h11});
    sb.push_back('{rd: 1'b0, addr: 8'h00, data: 8'h22});
    bus_start;
    send_byte(8'h42, a);
    send_byte(8'hFF, a);
    send_byte(8'h11, a);
    send_byte(8'h22, a);
    bus_stop;
    cyc(4);
    chk("wrap_sb_empty", 8'(sb.size()), 8'd0);

    // Two-byte read: master ACK, then NA
    set_ptr(8'h0A);
    sb.push_back('{rd: 1'b1, addr: 8'h0A, data: 8'h00});
    sb.push_back('{rd: 1'b1, addr: 8'h0B, data: 8'h00});
    bus_start;
    send_byte(8'h43, a);
    recv_byte(1'b1, v); chk("rd2_byte0", v, 8'h76);
    recv_byte(1'b0, v); chk("rd2_byte1", v, 8'hAE);
    bus_stop;
    cyc(4);
    chk("rd2_sb_empty", 8'(sb.size()), 8'd0);

    // Reset while the target is holding a 0 data bit
    set_ptr(8'h0A);
    sb.push_back('{rd: 1'b1, addr: 8'h0A, data: 8'h00});
    bus_start;
    send_byte(8'h43, a);
    cyc(4);
    chk("rst_mid_driving", 8'(dbg[5]), 8'd1);
    mon_oe_en = 1'b0;
    sccb_reset_n = 1'b0;
    cyc(2);
    chk("rst_mid_oe", 8'(dbg[5]), 8'd0);
    chk("rst_mid_line", 8'(sio_d), 8'd1);
    chk("rst_mid_busy", 8'(busy), 8'd0);
    sio_c = 1'b1; m_low = 1'b0;
    cyc(4);
    sccb_reset_n = 1'b1;
    cyc(4);
    mon_oe_en = 1'b1;
    chk("rst_after_busy", 8'(busy), 8'd0);
    chk("final_sb_empty", 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
